// File: rtl/fma_sum_normalizer.sv
// Sum/carry resolve stage for the aligned product path: adds the pair,
// takes sign and magnitude, then counts leading zeros and normalizes.
module fma_sum_normalizer #(
    parameter int SIG_WIDTH = 23,
    parameter int TAG_WIDTH = 4,
    parameter int LZC_WIDTH = 6,
    localparam int W = 2 * (SIG_WIDTH + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_s,
    input  logic [W-1:0]         in_c,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [W-1:0]         out_mag,
    output logic [W-1:0]         out_norm,
    output logic [LZC_WIDTH-1:0] out_lzc,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic                 r_v1, r_v2, r_v3;
    logic [W-1:0]         r_sum1;
    logic [TAG_WIDTH-1:0] r_tag1, r_tag2, r_tag3;
    logic                 r_sign2, r_sign3;
    logic [W-1:0]         r_mag2, r_mag3, r_norm3;
    logic [LZC_WIDTH-1:0] r_lzc3;
    logic                 r_zero3;

    logic                 w_en;
    logic [W-1:0]         w_sum;
    logic [W-1:0]         w_neg;
    logic [LZC_WIDTH-1:0] w_lzc;
    logic [W-1:0]         w_norm;
    logic                 w_zero;

    // Whole pipe stalls together; bubbles are not squeezed out.
    assign w_en     = !r_v3 || out_ready;
    assign in_ready = w_en;
    assign w_sum    = in_s + in_c;
    assign w_neg    = ~r_sum1 + {{(W-1){1'b0}}, 1'b1};
    assign w_zero   = (r_mag2 == '0);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        w_lzc = LZC_WIDTH'(W);
        for (int i = 0; i < W; i++) begin
            if (r_mag2[i]) w_lzc = LZC_WIDTH'(W - 1 - i);
        end
        w_norm = r_mag2 << w_lzc;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_sum1  <= '0;
            r_tag1  <= '0;
            r_sign2 <= 1'b0;
            r_mag2  <= '0;
            r_tag2  <= '0;
            r_sign3 <= 1'b0;
            r_mag3  <= '0;
            r_norm3 <= '0;
            r_lzc3  <= '0;
            r_zero3 <= 1'b0;
            r_tag3  <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (in_valid) begin
                r_sum1 <= w_sum;
                r_tag1 <= in_tag;
            end
            if (r_v1) begin
                r_sign2 <= r_sum1[W-1];
                r_mag2  <= r_sum1[W-1] ? w_neg : r_sum1;
                r_tag2  <= r_tag1;
            end
            if (r_v2) begin
                r_sign3 <= r_sign2 && !w_zero;
                r_mag3  <= r_mag2;
                r_norm3 <= w_norm;
                r_lzc3  <= w_lzc;
                r_zero3 <= w_zero;
                r_tag3  <= r_tag2;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_sign  = r_sign3;
    assign out_mag   = r_mag3;
    assign out_norm  = r_norm3;
    assign out_lzc   = r_lzc3;
    assign out_zero  = r_zero3;
    assign out_tag   = r_tag3;

endmodule
